// File: rtl/grid_scanout_pkg.sv
// grid_scanout_pkg: default raster timing, grid geometry and colours shared by the scanout path.
package grid_scanout_pkg;
    localparam int DEF_GRID_ROWS = 30;
    localparam int DEF_GRID_COLS = 40;
    localparam int DEF_CELL_PX   = 8;
    localparam int DEF_H_ACTIVE  = 320;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 8;
    localparam int DEF_H_BP      = 56;
    localparam int DEF_V_ACTIVE  = 240;
    localparam int DEF_V_FP      = 4;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 16;
    localparam logic [23:0] DEF_FG_RGB = 24'hFFFFFF;
    localparam logic [23:0] DEF_BG_RGB = 24'h000000;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } vid_ctl_t;
endpackage

// File: rtl/video_timing_gen.sv
// video_timing_gen: free-running h/v raster counters with unregistered region decode.
// o_last marks the final cycle of a frame so the consumer can snapshot its source data.
module video_timing_gen
    import grid_scanout_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [HW-1:0] o_h,
    output logic [VW-1:0] o_v,
    output vid_ctl_t      o_ctl,
    output logic          o_last
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          w_h_last;
    logic          w_v_last;

    always_comb begin
        w_h_last  = r_h == HW'(H_TOTAL - 1);
        w_v_last  = r_v == VW'(V_TOTAL - 1);
        o_h       = r_h;
        o_v       = r_v;
        o_last    = w_h_last && w_v_last;
        o_ctl.de  = r_h < HW'(H_ACTIVE) && r_v < VW'(V_ACTIVE);
        o_ctl.hs  = r_h >= HW'(H_ACTIVE + H_FP) && r_h < HW'(H_ACTIVE + H_FP + H_SYNC);
        o_ctl.vs  = r_v >= VW'(V_ACTIVE + V_FP) && r_v < VW'(V_ACTIVE + V_FP + V_SYNC);
        o_ctl.fs  = r_h == '0 && r_v == '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else begin
            r_h <= w_h_last ? '0 : r_h + 1'b1;
            if (w_h_last)
                r_v <= w_v_last ? '0 : r_v + 1'b1;
        end
    end
endmodule

// File: rtl/grid_scanout.sv
// grid_scanout: expands a per-frame snapshot of the cell grid into registered raster video.
// The snapshot is taken on the last cycle of each frame so a frame never shows a torn grid.
module grid_scanout
    import grid_scanout_pkg::*;
#(
    parameter int GRID_ROWS = DEF_GRID_ROWS,
    parameter int GRID_COLS = DEF_GRID_COLS,
    parameter int CELL_PX   = DEF_CELL_PX,
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter logic [23:0] FG_RGB = DEF_FG_RGB,
    parameter logic [23:0] BG_RGB = DEF_BG_RGB
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [GRID_ROWS*GRID_COLS-1:0] grid_bits,
    output logic [23:0]                    vid_rgb,
    output logic                           vid_de,
    output logic                           vid_hs,
    output logic                           vid_vs,
    output logic                           frame_start
);
    localparam int N  = GRID_ROWS * GRID_COLS;
    localparam int IW = $clog2(N);
    localparam int SH = $clog2(CELL_PX);
    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    if (GRID_ROWS * CELL_PX != V_ACTIVE || GRID_COLS * CELL_PX != H_ACTIVE ||
        (CELL_PX & (CELL_PX - 1)) != 0) begin : g_bad_geometry
        $error("grid_scanout: grid * CELL_PX must equal the active area and CELL_PX must be a power of two");
    end

    logic [HW-1:0] w_h;
    logic [VW-1:0] w_v;
    vid_ctl_t      w_ctl;
    vid_ctl_t      r_ctl;
    logic          w_last;
    logic [IW-1:0] w_col;
    logic [IW-1:0] w_row;
    logic [IW-1:0] w_idx;
    logic          w_pix;
    logic [N-1:0]  r_frame_buf;
    logic [23:0]   r_rgb;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HW(HW), .VW(VW)
    ) u_timing (
        .clk   (clk),
        .reset (reset),
        .o_h   (w_h),
        .o_v   (w_v),
        .o_ctl (w_ctl),
        .o_last(w_last)
    );

    // Index is forced to 0 outside the active area so it never leaves the grid.
    always_comb begin
        w_col = IW'(w_h >> SH);
        w_row = IW'(w_v >> SH);
        w_idx = w_ctl.de ? w_row * IW'(GRID_COLS) + w_col : '0;
        w_pix = r_frame_buf[w_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_buf <= '0;
            r_rgb       <= '0;
            r_ctl       <= '0;
        end else begin
            if (w_last)
                r_frame_buf <= grid_bits;
            r_rgb <= w_ctl.de ? (w_pix ? FG_RGB : BG_RGB) : '0;
            r_ctl <= w_ctl;
        end
    end

    assign vid_rgb     = r_rgb;
    assign vid_de      = r_ctl.de;
    assign vid_hs      = r_ctl.hs;
    assign vid_vs      = r_ctl.vs;
    assign frame_start = r_ctl.fs;
endmodule
